// File: rtl/seven_segment_reader.sv
// Seven-segment display reader: synchronises the segment lines, filters
// glitches with a stability window, decodes stable patterns back to hex
// digits and checks that the digits form a mod-16 up-count.
module seven_segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             pattern_err,
    output logic             seq_ok,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

    typedef enum logic {StSearch, StTrack} state_e;

    state_e           state_q, state_d;
    logic [6:0]       sync1_q, sync2_q;
    logic [6:0]       cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [6:0]       acc_q, acc_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       expected_q, expected_d;
    logic             digit_valid_q, digit_valid_d;
    logic             pattern_err_q, pattern_err_d;
    logic             seq_ok_q, seq_ok_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             accept;
    logic             is_digit;
    logic             is_blank;
    logic [3:0]       dec_val;

    // Two-flop synchroniser on the whole pattern vector {g,f,e,d,c,b,a}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 7'h00;
            sync2_q <= 7'h00;
        end else begin
            sync1_q <= {g, f, e, d, c, b, a};
            sync2_q <= sync1_q;
        end
    end

    // Stability filter: one accept per distinct pattern that held long enough
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        accept = (cnt_q == CntMax) && (cand_q == sync2_q) && (cand_q != acc_q);
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 8'd0;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (accept) begin
            acc_d = cand_q;
        end
    end

    // Pattern decoder for the accepted candidate
    always_comb begin
        is_digit = 1'b1;
        is_blank = 1'b0;
        dec_val  = 4'h0;
        case (cand_q)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default: is_digit = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any legal digit locks, blank or illegal drops lock
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = is_digit ? StTrack : StSearch;
        end
    end

    // FSM outputs: next values of the registered pulses, digit and counters
    always_comb begin
        digit_d       = digit_q;
        expected_d    = expected_q;
        digit_valid_d = 1'b0;
        pattern_err_d = 1'b0;
        seq_ok_d      = 1'b0;
        seq_err_d     = 1'b0;
        err_count_d   = err_count_q;
        if (accept) begin
            if (is_digit) begin
                digit_d       = dec_val;
                digit_valid_d = 1'b1;
                expected_d    = dec_val + 4'd1;
                if (state_q == StTrack) begin
                    seq_ok_d  = (dec_val == expected_q);
                    seq_err_d = (dec_val != expected_q);
                end
            end else if (!is_blank) begin
                pattern_err_d = 1'b1;
            end
        end
        if ((pattern_err_d || seq_err_d) && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    assign locked = (state_q == StTrack);

    // Filter, decoded digit and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q        <= 7'h00;
            cnt_q         <= 8'd0;
            acc_q         <= 7'h00;
            digit_q       <= 4'h0;
            expected_q    <= 4'h0;
            digit_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            seq_ok_q      <= 1'b0;
            seq_err_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            digit_q       <= digit_d;
            expected_q    <= expected_d;
            digit_valid_q <= digit_valid_d;
            pattern_err_q <= pattern_err_d;
            seq_ok_q      <= seq_ok_d;
            seq_err_q     <= seq_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign pattern_err = pattern_err_q;
    assign seq_ok      = seq_ok_q;
    assign seq_err     = seq_err_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side counterpart of the hex seven-segment driver: samples the seven active-high segment lines (a..g) of a display being driven.
- Filters glitches with a stability window and decodes each newly stable pattern back to a 4-bit hex digit.
- Checks that successive digits form a mod-16 up-count and reports lock/sequence errors.
- Used as an on-board self-check and scoreboard for counter-driven display outputs.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles a synchronised pattern must hold before acceptance; legal range 1..255.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low; clears all state
- a, b, c, d, e, f, g  input  1 each  segment lines, active-high; asynchronous to clk
- digit  output  4  last accepted digit value
- digit_valid  output  1  one-cycle pulse when a new digit is accepted
- pattern_err  output  1  one-cycle pulse when a non-hex, non-blank pattern is accepted
- seq_ok  output  1  one-cycle pulse: accepted digit equals expected value
- seq_err  output  1  one-cycle pulse: accepted digit differs from expected value
- locked  output  1  high while the FSM is in TRACK
- err_count  output  ERR_W  saturating count of pattern_err plus seq_err events

Behaviour:
- Pattern vector P = {g,f,e,d,c,b,a}. The legal set for digits 0..F is 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex).
- Blank is P=00. Every other value is illegal.
- Synchroniser: two flops per line, giving sync2.
- Stability filter:
  - If sync2 != cand: load cand<=sync2 and cnt<=0.
  - Otherwise, if cnt<STABLE_CYCLES-1: cnt increments.
  - Accept when cnt==STABLE_CYCLES-1, cand==sync2 and cand != acc. On accept, acc<=cand; exactly one event is produced per distinct stable pattern.
- Latency: a clean input change produces its event pulse in the cycle following rising edge STABLE_CYCLES+3, counted from the first edge after the change.
  - Example: STABLE_CYCLES=4 gives the pulse after edge 7.
- Glitch rule: any change shorter than STABLE_CYCLES synchronised cycles produces no event. A pattern returning to acc produces no event.
- FSM states: SEARCH (reset) and TRACK.
- Accept of a legal digit v:
  - Always: digit<=v, digit_valid=1, expected<=v+1 mod 16 (F wraps to 0).
  - In SEARCH: go to TRACK. No seq_ok or seq_err.
  - In TRACK, v==expected: seq_ok=1, stay in TRACK.
  - In TRACK, v!=expected: seq_err=1, err_count+1, stay in TRACK (resynchronises to v).
- Accept of blank: go to SEARCH. No pulses, no count. digit holds its value.
- Accept of an illegal pattern: pattern_err=1, err_count+1, go to SEARCH. digit holds its value.
- Pulse rules:
  - All pulses are registered and last exactly one cycle.
  - digit_valid is mutually exclusive with pattern_err.
  - seq_ok and seq_err only accompany digit_valid.
- err_count saturates at 2^ERR_W-1 and never wraps.
- Reset values:
  - digit=0, digit_valid=0, pattern_err=0, seq_ok=0, seq_err=0, locked=0, err_count=0.
  - Synchroniser flops, cand, cnt and acc are all cleared to 0, so the reset pattern reads as blank and raises no event.
  - expected=0; FSM in SEARCH.
- Reset asserted mid-filter or mid-track aborts immediately. After release, the first stable legal digit re-enters TRACK without a sequence check.

Test Plan:
- Reset release with all inputs 0 held for 50 cycles -> no pulses; locked=0; err_count=0.
- STABLE_CYCLES=4; drive 3F then 06 then 5B, each held 10 cycles -> digit 0,1,2. Pulses: digit_valid only on 0 (lock, pulse after edge 7), then digit_valid+seq_ok on 1 and 2. locked=1 from the first accept.
- Drive 71 (F) then 3F (0) while locked -> seq_ok on the 0 (wrap check); err_count unchanged.
- While locked at digit 2, drive 4F for 2 cycles then back to 5B -> no event; digit stays 2.
- Drive 6D (5) after digit 2 -> seq_err, err_count=1, digit=5. Then 7D (6) -> seq_ok.
- Drive illegal 01 -> pattern_err, err_count+1, locked=0. Then 06 -> digit_valid with no seq pulse, locked=1. Force 300 errors with ERR_W=8 -> err_count saturates at 255.
